nf_uart_rx_fifo: RTL and testbench
==================================

Name: nf_uart_rx_fifo

Overview:
UART 8N1 receiver with a show-ahead receive FIFO. It consumes the serial stream that the system-level bench drives onto the top-level uart_rx pin, for example the "Hello World!" message. It sits directly between the uart_rx pad and the UART register interface on the peripheral bus. The bus side sees a valid/ready byte stream plus error pulses.

Parameters:
DEPTH, 4, number of FIFO entries; must be a power of two and >= 2
CW, 16, width of the baud compare value

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
uart_rx  input  1  serial line, idle high, asynchronous to clk
rx_en  input  1  receiver enable
comp  input  CW  clocks per bit (50 MHz / 115200 = 434); valid range 4..2^CW-1
rx_data  output  8  byte at FIFO head (show-ahead)
rx_valid  output  1  FIFO not empty
rx_ready  input  1  consumer accepts head byte when rx_valid & rx_ready
fifo_cnt  output  log2(DEPTH)+1  current FIFO occupancy
frame_err  output  1  one-cycle pulse: stop bit sampled low
overflow  output  1  one-cycle pulse: byte dropped because FIFO full

Behaviour:
- Reset (async, resetn=0):
  - Synchroniser flops = 1; FSM = IDLE; counters = 0; FIFO empty.
  - rx_valid=0, rx_data=0, fifo_cnt=0, frame_err=0, overflow=0.
- Reset mid-frame aborts the frame; the partial byte is lost; FIFO contents are cleared.
- uart_rx passes through a 2-flop synchroniser; rxs is the synchronised value. All decisions use rxs.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if rx_en=1 and rxs=0, latch comp into comp_l, clear the counter, go START. Call this cycle t0.
  - START: count to comp_l/2 (integer divide). At t0+comp_l/2, if rxs=0 go DATA and clear the counter. If rxs=1 (glitch), go IDLE with no error.
  - DATA: data bit n (n=0..7, LSB first) is sampled at t0+comp_l/2+(n+1)*comp_l into shift register bit n. After bit 7, go STOP.
  - STOP: sample at t0+comp_l/2+9*comp_l.
    - rxs=1: push the byte.
    - rxs=0: pulse frame_err and discard the byte.
    - Either way go IDLE in the next cycle. A new start may be detected from t0+comp_l/2+9*comp_l+1 onward.
- A comp change mid-frame has no effect; comp_l is fixed for the whole frame.
- rx_en=0 mid-frame: the current frame completes normally. rx_en only gates start detection in IDLE.
- FIFO push: in the stop-sample cycle.
  - rx_valid rises the following cycle when the FIFO was empty.
  - rx_data shows the head entry, registered from the storage array. rx_data is undefined-free: it holds the last value when empty.
- Pop: when rx_valid & rx_ready at a clock edge, the head advances; fifo_cnt decrements.
- Full (fifo_cnt=DEPTH):
  - Push without pop drops the new byte and pulses overflow for 1 cycle. Stored data is unchanged.
  - Push and pop in the same cycle: both take effect, no overflow, fifo_cnt unchanged.
- Empty: rx_ready is ignored; no underflow state exists.
- Pointers are log2(DEPTH) bits and wrap naturally. fifo_cnt is tracked separately, range 0..DEPTH.
- frame_err and overflow are never asserted together. A framing error does not push, so no overflow can occur.

Test Plan:
- comp=434, rx_ready=1, send 0x48 ('H') 8N1 at 434 clk/bit:
  - rx_valid pulses for 1 cycle with rx_data=0x48.
  - The push occurs exactly t0+217+9*434 cycles after start detection.
  - frame_err=0.
- comp=434, rx_ready=0, send "Hello" (5 bytes, DEPTH=4):
  - After byte 4, fifo_cnt=4 and rx_data=0x48.
  - Byte 5 produces one overflow pulse; fifo_cnt stays 4.
  - Then hold rx_ready=1: pops 0x48,0x65,0x6C,0x6C in order, then rx_valid=0.
- Frame 0x55 with the stop bit driven low -> one frame_err pulse, fifo_cnt stays 0, and the next valid frame 0xA3 is received correctly.
- Low glitch of 100 cycles on uart_rx with comp=434 -> FSM returns to IDLE at t0+217, no push, no frame_err.
- Edge cases:
  - FIFO full and rx_ready=1 in the exact push cycle -> no overflow; fifo_cnt stays 4; order is preserved across pointer wrap.
  - resetn pulsed low mid-DATA -> all outputs 0 asynchronously, and the next full frame 0x0F is received correctly.

Source files
------------

// File: rtl/nf_uart_rx_fifo_if.sv
// rtl/nf_uart_rx_fifo_if.sv - receive byte stream and status bundle between the UART receiver and the bus side
interface nf_uart_rx_fifo_if #(
    parameter int DEPTH = 4
);
    localparam int CNTW = $clog2(DEPTH) + 1;

    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            rx_ready;
    logic [CNTW-1:0] fifo_cnt;
    logic            frame_err;
    logic            overflow;

    modport master (
        output rx_data,
        output rx_valid,
        output fifo_cnt,
        output frame_err,
        output overflow,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  fifo_cnt,
        input  frame_err,
        input  overflow,
        output rx_ready
    );
endinterface

// File: rtl/nf_uart_rx_fifo.sv
// rtl/nf_uart_rx_fifo.sv - UART 8N1 receiver feeding a show-ahead receive FIFO
module nf_uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  uart_rx,
    input  logic                  rx_en,
    input  logic [CW-1:0]         comp,
    nf_uart_rx_fifo_if.master     rx_if
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic [CW-1:0]   comp_l_q, comp_l_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            frame_err_q, frame_err_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      mem_q [DEPTH];

    logic            rxs;
    logic [CW-1:0]   half_m1;
    logic [CW-1:0]   comp_m1;
    logic            half_hit;
    logic            bit_hit;
    logic            push;
    logic            pop;
    logic            full;
    logic            push_ok;

    assign rxs      = sync_q[1];
    assign half_m1  = (comp_l_q >> 1) - 1'b1;
    assign comp_m1  = comp_l_q - 1'b1;
    assign half_hit = (bit_cnt_q == half_m1);
    assign bit_hit  = (bit_cnt_q == comp_m1);

    // Receiver state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame sequencing: start qualification at half a bit, then one sample per bit period
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (rx_en && !rxs) state_d = START;
            START: if (half_hit) state_d = rxs ? IDLE : DATA;
            DATA:  if (bit_hit && (bit_idx_q == 3'd7)) state_d = STOP;
            STOP:  if (bit_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-state datapath: bit timing counter, shift register, push and framing error request
    always_comb begin
        sync_d      = {sync_q[0], uart_rx};
        comp_l_d    = comp_l_q;
        bit_cnt_d   = bit_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_en && !rxs) begin
                    comp_l_d  = comp;
                    bit_cnt_d = '0;
                end
            end
            START: begin
                bit_idx_d = 3'd0;
                bit_cnt_d = half_hit ? '0 : bit_cnt_q + 1'b1;
            end
            DATA: begin
                if (bit_hit) begin
                    shift_d[bit_idx_q] = rxs;
                    bit_idx_d          = bit_idx_q + 1'b1;
                    bit_cnt_d          = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_hit) begin
                    bit_cnt_d   = '0;
                    push        = rxs;
                    frame_err_d = !rxs;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // FIFO bookkeeping; the head register is reloaded with the entry that will be at the head after this edge
    always_comb begin
        full       = (cnt_q == FULL_CNT);
        pop        = (cnt_q != '0) && rx_if.rx_ready;
        push_ok    = push && (!full || pop);
        overflow_d = push && full && !pop;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        rx_data_d  = rx_data_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop) cnt_d = cnt_q + 1'b1;
        if (!push_ok && pop) cnt_d = cnt_q - 1'b1;
        if (cnt_d != '0) begin
            if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
                rx_data_d = shift_q;
            end else begin
                rx_data_d = mem_q[rd_ptr_d];
            end
        end
    end

    // Control and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q      <= 2'b11;
            comp_l_q    <= '0;
            bit_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            rx_data_q   <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            comp_l_q    <= comp_l_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            rx_data_q   <= rx_data_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage array; contents are meaningful only where the occupancy count says so
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= shift_q;
    end

    assign rx_if.rx_data   = rx_data_q;
    assign rx_if.rx_valid  = (cnt_q != '0);
    assign rx_if.fifo_cnt  = cnt_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.overflow  = overflow_q;
endmodule

// File: tb/tb_nf_uart_rx_fifo.sv
// tb/tb_nf_uart_rx_fifo.sv - scoreboard bench for the UART receiver and receive FIFO
module tb_nf_uart_rx_fifo;
    localparam int DEPTH = 4;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          resetn;
    logic          uart_rx;
    logic          rx_en;
    logic [CW-1:0] comp;

    nf_uart_rx_fifo_if #(.DEPTH(DEPTH)) rx_if ();

    nf_uart_rx_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .uart_rx (uart_rx),
        .rx_en   (rx_en),
        .comp    (comp),
        .rx_if   (rx_if.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q [$];
    int n_cmp   = 0;
    int n_err   = 0;
    int fe_seen = 0;
    int ov_seen = 0;
    int pops    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted byte and counts status pulses
    always @(negedge clk) begin
        if (resetn) begin
            if (rx_if.frame_err) fe_seen++;
            if (rx_if.overflow)  ov_seen++;
            if (rx_if.frame_err && rx_if.overflow) begin
                n_cmp++;
                n_err++;
                $display("FAIL err_exclusive: frame_err and overflow both 1");
            end
            if (rx_if.rx_valid && rx_if.rx_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pop: got 0x%0h, expected no byte", rx_if.rx_data);
                end else begin
                    check("pop_data", rx_if.rx_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop, input int c);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1 uart_rx = fr[i];
            repeat (c - 1) @(posedge clk);
        end
        @(posedge clk); #1 uart_rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int rise;
        int p0;
        logic [7:0] hello [5];
        hello[0] = 8'h48; hello[1] = 8'h65; hello[2] = 8'h6C; hello[3] = 8'h6C; hello[4] = 8'h6F;

        resetn = 1'b0; uart_rx = 1'b1; rx_en = 1'b1; comp = 16'd434; rx_if.rx_ready = 1'b1;
        idle(3);
        check("rst_valid", rx_if.rx_valid, 0);
        check("rst_data", rx_if.rx_data, 0);
        check("rst_cnt", rx_if.fifo_cnt, 0);
        check("rst_frame_err", rx_if.frame_err, 0);
        check("rst_overflow", rx_if.overflow, 0);
        resetn = 1'b1;
        idle(5);

        // Single byte with latency measurement from start-bit drive to rx_valid
        exp_q.push_back(8'h48);
        rise = -1;
        fork
            send_byte(8'h48, 1'b1, 434);
            begin
                @(posedge clk); #1 c0 = cyc;
                for (int i = 0; i < 5000; i++) begin
                    @(negedge clk);
                    if (rx_if.rx_valid) begin
                        rise = cyc - c0;
                        break;
                    end
                end
                check("push_latency", rise, 2 + 217 + 9 * 434 + 1);
                @(negedge clk);
                check("valid_one_cycle", rx_if.rx_valid, 0);
            end
        join
        idle(10);
        check("h_no_frame_err", fe_seen, 0);
        check("h_cnt", rx_if.fifo_cnt, 0);
        check("h_scoreboard_empty", exp_q.size(), 0);

        // Fill and overflow with "Hello"
        rx_if.rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(hello[i]);
        for (int i = 0; i < 4; i++) send_byte(hello[i], 1'b1, 434);
        idle(20);
        check("hello_cnt4", rx_if.fifo_cnt, 4);
        check("hello_head", rx_if.rx_data, 8'h48);
        send_byte(hello[4], 1'b1, 434);
        idle(20);
        check("hello_overflow", ov_seen, 1);
        check("hello_cnt_after_ovf", rx_if.fifo_cnt, 4);
        check("hello_head_after_ovf", rx_if.rx_data, 8'h48);
        rx_if.rx_ready = 1'b1;
        idle(10);
        check("hello_drained_valid", rx_if.rx_valid, 0);
        check("hello_scoreboard_empty", exp_q.size(), 0);

        // Framing error followed by a good frame
        send_byte(8'h55, 1'b0, 434);
        idle(20);
        check("fe_pulse", fe_seen, 1);
        check("fe_cnt", rx_if.fifo_cnt, 0);
        exp_q.push_back(8'hA3);
        send_byte(8'hA3, 1'b1, 434);
        idle(20);
        check("a3_scoreboard_empty", exp_q.size(), 0);
        check("a3_no_new_fe", fe_seen, 1);

        // Short low glitch is rejected at the half-bit check
        p0 = pops;
        @(posedge clk); #1 uart_rx = 1'b0;
        idle(100);
        uart_rx = 1'b1;
        idle(400);
        check("glitch_no_fe", fe_seen, 1);
        check("glitch_no_push", pops, p0);
        check("glitch_cnt", rx_if.fifo_cnt, 0);

        // Full FIFO with a pop in the exact push cycle, across pointer wrap
        comp = 16'd20;
        rx_if.rx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1, 20);
        idle(5);
        check("full_cnt", rx_if.fifo_cnt, 4);
        exp_q.push_back(8'h05);
        fork
            send_byte(8'h05, 1'b1, 20);
            begin
                @(posedge clk); #1;
                repeat (192) @(posedge clk);
                #1 rx_if.rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_if.rx_ready = 1'b0;
            end
        join
        idle(5);
        check("pushpop_cnt", rx_if.fifo_cnt, 4);
        check("pushpop_no_overflow", ov_seen, 1);
        check("pushpop_head", rx_if.rx_data, 8'h02);
        rx_if.rx_ready = 1'b1;
        idle(10);
        check("wrap_drained_valid", rx_if.rx_valid, 0);
        check("wrap_scoreboard_empty", exp_q.size(), 0);

        // Asynchronous reset in the middle of a data bit
        rx_if.rx_ready = 1'b0;
        exp_q.push_back(8'h7E);
        send_byte(8'h7E, 1'b1, 20);
        idle(5);
        check("pre_rst_cnt", rx_if.fifo_cnt, 1);
        check("pre_rst_data", rx_if.rx_data, 8'h7E);
        fork
            send_byte(8'hC3, 1'b1, 20);
            begin
                repeat (70) @(posedge clk);
                #1 resetn = 1'b0;
                #1;
                check("async_rst_valid", rx_if.rx_valid, 0);
                check("async_rst_data", rx_if.rx_data, 0);
                check("async_rst_cnt", rx_if.fifo_cnt, 0);
                check("async_rst_frame_err", rx_if.frame_err, 0);
                check("async_rst_overflow", rx_if.overflow, 0);
                exp_q.delete();
            end
        join
        idle(1);
        resetn = 1'b1;
        rx_if.rx_ready = 1'b1;
        idle(5);
        exp_q.push_back(8'h0F);
        send_byte(8'h0F, 1'b1, 20);
        idle(20);
        check("post_rst_scoreboard_empty", exp_q.size(), 0);
        check("post_rst_fe", fe_seen, 1);
        check("post_rst_ovf", ov_seen, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
